sd_dma_sec_seq: RTL

Parametrised multi-sector SD sequencer between the DMA register front-end and the SD card read/write controllers. It accepts a sector address, a sector count and a direction (read or write) on a request rising edge and captures all three. It then issues one start pulse per sector to the selected controller, and advances the address on each falling edge of that controller's busy. It adds abort, per-sector timeout, a completed-sector counter and a status code.

---
 rtl/sd_dma_sec_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sd_dma_sec_seq.sv
// Multi-sector SD sequencer: issues one start pulse per sector to the read or
// write controller, steps the sector address on each busy falling edge, and
// reports completion with timeout/abort/zero-count status.
module sd_dma_sec_seq #(
    parameter int unsigned          ADDR_W      = 32,
    parameter int unsigned          CNT_W       = 16,
    parameter int unsigned          TO_W        = 24,
    parameter logic [TO_W-1:0]      TIMEOUT_CYC = 24'd10_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [CNT_W-1:0]  req_cnt,
    input  logic              abort,
    input  logic              rd_busy,
    input  logic              wr_busy,
    output logic              rd_start_en,
    output logic              wr_start_en,
    output logic [ADDR_W-1:0] sec_addr,
    output logic              busy,
    output logic              done,
    output logic              done_lvl,
    output logic [1:0]        status,
    output logic [CNT_W-1:0]  sec_done_cnt
);

    // Counter value that, after one more increment, reaches TIMEOUT_CYC-1.
    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT_CYC - TO_W'(2);

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_ABORT   = 2'd2;
    localparam logic [1:0] ST_ZERO    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t            r_state,    w_state_nxt;
    logic              r_req_q;
    logic              r_busy_q;
    logic              r_dir,      w_dir_nxt;
    logic [ADDR_W-1:0] r_addr,     w_addr_nxt;
    logic [CNT_W-1:0]  r_rem,      w_rem_nxt;
    logic [TO_W-1:0]   r_to_cnt,   w_to_cnt_nxt;
    logic              r_rd_start, w_rd_start_nxt;
    logic              r_wr_start, w_wr_start_nxt;
    logic [ADDR_W-1:0] r_sec_addr, w_sec_addr_nxt;
    logic              r_busy,     w_busy_nxt;
    logic              r_done,     w_done_nxt;
    logic              r_done_lvl, w_done_lvl_nxt;
    logic [1:0]        r_status,   w_status_nxt;
    logic [CNT_W-1:0]  r_sec_cnt,  w_sec_cnt_nxt;

    logic w_sel_busy;
    logic w_fall;
    logic w_req_edge;
    logic w_to_exp;

    assign w_sel_busy = r_dir ? wr_busy : rd_busy;
    assign w_fall     = r_busy_q & ~w_sel_busy;
    assign w_req_edge = req & ~r_req_q;
    assign w_to_exp   = (r_to_cnt == TO_LAST);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_req_q    <= 1'b0;
            r_busy_q   <= 1'b0;
            r_dir      <= 1'b0;
            r_addr     <= '0;
            r_rem      <= '0;
            r_to_cnt   <= '0;
            r_rd_start <= 1'b0;
            r_wr_start <= 1'b0;
            r_sec_addr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_done_lvl <= 1'b0;
            r_status   <= ST_OK;
            r_sec_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_req_q    <= req;
            r_busy_q   <= w_sel_busy;
            r_dir      <= w_dir_nxt;
            r_addr     <= w_addr_nxt;
            r_rem      <= w_rem_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_rd_start <= w_rd_start_nxt;
            r_wr_start <= w_wr_start_nxt;
            r_sec_addr <= w_sec_addr_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_done_lvl <= w_done_lvl_nxt;
            r_status   <= w_status_nxt;
            r_sec_cnt  <= w_sec_cnt_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_dir_nxt      = r_dir;
        w_addr_nxt     = r_addr;
        w_rem_nxt      = r_rem;
        w_to_cnt_nxt   = r_to_cnt;
        w_rd_start_nxt = 1'b0;
        w_wr_start_nxt = 1'b0;
        w_sec_addr_nxt = r_sec_addr;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_done_lvl_nxt = r_done_lvl;
        w_status_nxt   = r_status;
        w_sec_cnt_nxt  = r_sec_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_req_edge) begin
                    w_dir_nxt      = req_wr;
                    w_addr_nxt     = req_addr;
                    w_rem_nxt      = req_cnt;
                    w_busy_nxt     = 1'b1;
                    w_done_lvl_nxt = 1'b0;
                    w_status_nxt   = ST_OK;
                    w_sec_cnt_nxt  = '0;
                    if (req_cnt != '0) begin
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_state_nxt  = S_FINISH;
                        w_status_nxt = ST_ZERO;
                    end
                end
            end

            S_ISSUE: begin
                if (abort) begin
                    w_state_nxt  = S_FINISH;
                    w_status_nxt = ST_ABORT;
                end else begin
                    w_sec_addr_nxt = r_addr;
                    w_rd_start_nxt = ~r_dir;
                    w_wr_start_nxt = r_dir;
                    w_to_cnt_nxt   = '0;
                    w_state_nxt    = S_WAIT;
                end
            end

            S_WAIT: begin
                if (w_fall) begin
                    // Falling edge takes priority over a coincident timeout.
                    w_sec_cnt_nxt  = r_sec_cnt + CNT_W'(1);
                    w_sec_addr_nxt = r_sec_addr + ADDR_W'(1);
                    w_rem_nxt      = r_rem - CNT_W'(1);
                    if (r_rem == CNT_W'(1)) begin
                        w_state_nxt  = S_FINISH;
                        w_status_nxt = ST_OK;
                    end else if (abort) begin
                        w_state_nxt  = S_FINISH;
                        w_status_nxt = ST_ABORT;
                    end else begin
                        w_rd_start_nxt = ~r_dir;
                        w_wr_start_nxt = r_dir;
                        w_to_cnt_nxt   = '0;
                    end
                end else if (w_to_exp) begin
                    w_state_nxt  = S_FINISH;
                    w_status_nxt = ST_TIMEOUT;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end

            S_FINISH: begin
                w_done_nxt     = 1'b1;
                w_done_lvl_nxt = 1'b1;
                w_busy_nxt     = 1'b0;
                w_state_nxt    = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign rd_start_en  = r_rd_start;
    assign wr_start_en  = r_wr_start;
    assign sec_addr     = r_sec_addr;
    assign busy         = r_busy;
    assign done         = r_done;
    assign done_lvl     = r_done_lvl;
    assign status       = r_status;
    assign sec_done_cnt = r_sec_cnt;

endmodule
